state_uart_tx: RTL and testbench

Serializes the 8-bit encoded player word (`{rst, 0, firing, projectile_type, lane[3:0]}`) onto a UART TX line, 8N1, LSB first. It sits directly downstream of the player controller, in the same `clk` domain, and drives the board's UART TX pin toward the game host. A frame is sent whenever the filtered word differs from the last word sent. A heartbeat frame is also sent periodically so the host can recover from a dropped byte.

---
 rtl/state_uart_tx_pkg.sv | 23 ++
 rtl/state_uart_tx_bit_timer.sv | 35 +++
 rtl/state_uart_tx.sv | 132 +++++++++++++
 tb/tb_state_uart_tx.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/state_uart_tx_pkg.sv
// uart_pkg: shared types and constants for the player-word UART transmitter.
//   state_t       - transmitter FSM states
//   DATA_BITS     - data bits per frame (8N1)
//   STOP_BITS     - stop bits per frame
//   clks_per_bit  - rounded clock divider for a given clock rate and baud rate
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    localparam int DATA_BITS = 8;
    localparam int STOP_BITS = 1;

    // Round to nearest so e.g. 100 MHz / 9600 gives 10417 rather than truncating.
    function automatic int clks_per_bit(input longint clk_hz, input longint baud);
        return int'((clk_hz + (baud / 2)) / baud);
    endfunction

endpackage

// File: rtl/state_uart_tx_bit_timer.sv
// uart_bit_timer: free-running bit-period counter for the UART transmitter.
// Ports:
//   clk   - system clock, rising edge
//   rst   - asynchronous active-high reset
//   clear - holds the count at 0 (asserted while the transmitter is idle)
//   tick  - one-cycle pulse in the last cycle of each bit period
module uart_bit_timer #(
    parameter int CLKS_PER_BIT = 10416
) (
    input  logic clk,
    input  logic rst,
    input  logic clear,
    output logic tick
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] count;

    // Wrapping at LAST doubles as the reload on every state change after the
    // start bit, since those changes only ever happen on a tick.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear || (count == LAST)) begin
            count <= '0;
        end else begin
            count <= count + 1'b1;
        end
    end

    assign tick = !clear && (count == LAST);

endmodule

// File: rtl/state_uart_tx.sv
// state_uart_tx: sends the encoded player word over an 8N1 UART line, LSB
// first, whenever the (glitch-filtered) word changes, plus a periodic
// heartbeat resend of the current word.
// Ports:
//   clk        - system clock, rising edge
//   rst        - asynchronous active-high reset
//   data_in    - encoded player word, combinational source that may glitch
//   tx         - UART serial line, idle high
//   busy       - high while a start, data or stop bit is on the line
//   frame_done - one-cycle pulse in the last cycle of each stop bit
module state_uart_tx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT     = 10416,
    parameter int HEARTBEAT_CYCLES = 5_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       frame_done
);

    localparam int HW = (HEARTBEAT_CYCLES > 1) ? $clog2(HEARTBEAT_CYCLES) : 1;
    localparam logic [HW-1:0] HB_LAST  = HW'(HEARTBEAT_CYCLES - 1);
    localparam logic [2:0]    BIT_LAST = 3'(DATA_BITS - 1);

    state_t        state, state_d;
    logic [7:0]    sample, stable, last_sent, shreg;
    logic [7:0]    last_sent_d, shreg_d;
    logic [2:0]    bit_idx, bit_idx_d;
    logic [HW-1:0] hb_cnt, hb_cnt_d;
    logic          tick;

    uart_bit_timer #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_timer (
        .clk  (clk),
        .rst  (rst),
        .clear(state == IDLE),
        .tick (tick)
    );

    // A value only propagates to stable once it has been seen on two
    // consecutive edges, so single-cycle glitches never launch a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample <= '0;
            stable <= '0;
        end else begin
            sample <= data_in;
            if (data_in == sample) begin
                stable <= data_in;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_idx   <= '0;
            last_sent <= '0;
            hb_cnt    <= '0;
        end else begin
            state     <= state_d;
            shreg     <= shreg_d;
            bit_idx   <= bit_idx_d;
            last_sent <= last_sent_d;
            hb_cnt    <= hb_cnt_d;
        end
    end

    always_comb begin
        state_d     = state;
        shreg_d     = shreg;
        bit_idx_d   = bit_idx;
        last_sent_d = last_sent;
        hb_cnt_d    = hb_cnt;
        tx          = 1'b1;
        busy        = 1'b0;
        frame_done  = 1'b0;

        case (state)
            IDLE: begin
                // Change and heartbeat expiry together still give a single
                // frame, carrying the current stable value.
                if ((stable != last_sent) || (hb_cnt == HB_LAST)) begin
                    state_d     = START;
                    shreg_d     = stable;
                    last_sent_d = stable;
                    hb_cnt_d    = '0;
                    bit_idx_d   = '0;
                end else begin
                    hb_cnt_d = hb_cnt + 1'b1;
                end
            end
            START: begin
                tx   = 1'b0;
                busy = 1'b1;
                if (tick) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                tx   = shreg[0];
                busy = 1'b1;
                if (tick) begin
                    shreg_d = {1'b0, shreg[7:1]};
                    if (bit_idx == BIT_LAST) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx + 1'b1;
                    end
                end
            end
            STOP: begin
                busy = 1'b1;
                if (tick) begin
                    frame_done = 1'b1;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_state_uart_tx.sv
// tb_state_uart_tx: directed plus randomized checks of state_uart_tx against a
// frame-level reference model and a line decoder of the DUT's tx output.
module tb_state_uart_tx;

    localparam int CPB = 4;
    localparam int HB  = 100;
    localparam int FB  = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in;
    logic       tx, busy, frame_done;

    state_uart_tx #(
        .CLKS_PER_BIT    (CPB),
        .HEARTBEAT_CYCLES(HB)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .data_in   (data_in),
        .tx        (tx),
        .busy      (busy),
        .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // Reference model: filter registers plus a frame position counter.
    logic [7:0] m_sample, m_stable, m_last, m_word;
    int         m_hb;
    bit         m_active;
    int         m_pos;
    logic       e_tx, e_busy, e_fd;

    // Decoder of the DUT's line.
    int         d_cnt    = 0;
    logic [9:0] d_bits;
    logic [7:0] dut_words[$];
    int         fd_count = 0;
    int         idle_run = 0;
    int         last_gap = 0;

    function automatic logic frame_bit(input logic [7:0] w, input int k);
        if (k == 0) return 1'b0;
        if (k <= 8) return w[k-1];
        return 1'b1;
    endfunction

    task automatic model_reset();
        m_sample = '0;
        m_stable = '0;
        m_last   = '0;
        m_word   = '0;
        m_hb     = 0;
        m_active = 0;
        m_pos    = 0;
    endtask

    task automatic chk(input string tag, input logic got, input logic exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%b exp=%b", tag, cyc, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int got, input int exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s cyc=%0d got=%0d exp=%0d", tag, cyc, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        if (rst) begin
            model_reset();
        end else begin
            if (!m_active) begin
                if ((m_stable != m_last) || (m_hb == HB - 1)) begin
                    m_active = 1;
                    m_pos    = 0;
                    m_word   = m_stable;
                    m_last   = m_stable;
                    m_hb     = 0;
                end else if (m_hb < HB - 1) begin
                    m_hb++;
                end
            end else begin
                m_pos++;
                if (m_pos == FB) m_active = 0;
            end
            if (data_in == m_sample) m_stable = data_in;
            m_sample = data_in;
        end
        #1;
        cyc++;
        e_tx   = m_active ? frame_bit(m_word, m_pos / CPB) : 1'b1;
        e_busy = m_active;
        e_fd   = m_active && (m_pos == FB - 1);
        chk("tx", tx, e_tx);
        chk("busy", busy, e_busy);
        chk("frame_done", frame_done, e_fd);
        if (frame_done === 1'b1) fd_count++;
        // Decode the DUT line independently of the model.
        if (busy === 1'b1) begin
            if (d_cnt == 0) begin
                last_gap = idle_run;
                idle_run = 0;
            end
            if ((d_cnt % CPB) == (CPB / 2) && (d_cnt / CPB) < 10) d_bits[d_cnt / CPB] = tx;
            d_cnt++;
        end else begin
            idle_run++;
            if (d_cnt > 0) begin
                chk_int("frame_len", d_cnt, FB);
                chk("start_bit", d_bits[0], 1'b0);
                chk("stop_bit", d_bits[9], 1'b1);
                dut_words.push_back(d_bits[8:1]);
                d_cnt = 0;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_busy(input int limit);
        int k;
        k = 0;
        while (busy !== 1'b1 && k < limit) begin
            step();
            k++;
        end
        total++;
        assert (busy === 1'b1) else begin
            bad++;
            $error("FAIL wait_busy timeout cyc=%0d got=%b exp=1", cyc, busy);
        end
    endtask

    int         n_words;
    int         fd_before;
    logic [7:0] held, g;

    initial begin
        rst     = 1'b1;
        data_in = 8'h00;
        model_reset();
        run(3);
        chk("reset_tx", tx, 1'b1);
        chk("reset_busy", busy, 1'b0);
        chk("reset_fd", frame_done, 1'b0);
        rst = 1'b0;

        // Heartbeat after 100 idle cycles with a zero word.
        run(99);
        chk("hb_not_yet", busy, 1'b0);
        chk_int("hb_no_frames", dut_words.size(), 0);
        step();
        chk("hb_launch_busy", busy, 1'b1);
        chk("hb_launch_tx", tx, 1'b0);
        run(41);
        chk_int("hb_frames", dut_words.size(), 1);
        chk_int("hb_word", int'(dut_words[0]), 'h00);
        chk_int("hb_fd_count", fd_count, 1);

        // Word change 0x05.
        data_in = 8'h05;
        step();
        step();
        chk("chg_not_yet", busy, 1'b0);
        step();
        chk("chg_start_busy", busy, 1'b1);
        chk("chg_start_tx", tx, 1'b0);
        run(45);
        chk_int("chg_word", int'(dut_words[dut_words.size() - 1]), 'h05);

        // One-cycle glitch back to the already-sent value launches nothing.
        n_words = dut_words.size();
        data_in = 8'hC5;
        step();
        data_in = 8'h05;
        run(20);
        chk_int("glitch_no_frame", dut_words.size(), n_words);
        chk("glitch_idle", busy, 1'b0);

        // Heartbeat frame of 0x05 in flight; 0x06 then 0x26 arrive mid-frame.
        wait_busy(200);
        run(5);
        data_in = 8'h06;
        run(8);
        data_in = 8'h26;
        run(100);
        chk_int("latest_prev", int'(dut_words[dut_words.size() - 2]), 'h05);
        chk_int("latest_word", int'(dut_words[dut_words.size() - 1]), 'h26);
        chk_int("latest_gap", last_gap, 1);
        n_words = 0;
        foreach (dut_words[i]) if (dut_words[i] == 8'h06) n_words++;
        chk_int("never_06", n_words, 0);

        // Reset in the middle of a frame.
        data_in = 8'h05;
        wait_busy(20);
        run(16);
        fd_before = fd_count;
        rst = 1'b1;
        #1;
        model_reset();
        d_cnt = 0;
        chk("rst_mid_tx", tx, 1'b1);
        chk("rst_mid_busy", busy, 1'b0);
        chk("rst_mid_fd", frame_done, 1'b0);
        run(2);
        rst = 1'b0;
        wait_busy(20);
        run(45);
        chk_int("rst_fresh_word", int'(dut_words[dut_words.size() - 1]), 'h05);
        chk_int("rst_fd_once", fd_count, fd_before + 1);

        // MSB-only word.
        data_in = 8'h80;
        wait_busy(20);
        run(45);
        chk_int("msb_word", int'(dut_words[dut_words.size() - 1]), 'h80);

        // Randomized holds, glitches and changes; the model checks every cycle.
        held = 8'h80;
        for (int it = 0; it < 150; it++) begin
            case ($urandom_range(0, 3))
                0: begin
                    g       = 8'($urandom);
                    data_in = g;
                    step();
                    data_in = held;
                end
                1: held = held ^ 8'(1 << $urandom_range(0, 7));
                default: held = 8'($urandom);
            endcase
            data_in = held;
            run($urandom_range(1, 60));
        end
        run(200);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
